// File: rtl/writeback_stage.sv
// LC-3b write-back stage: MEM/WB register, regfile write-back mux, architectural
// condition codes, BR resolution and a retired-instruction counter.
module writeback_stage #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall_in,
  input  logic                 flush_in,
  input  logic                 mem_valid,
  input  logic                 mem_load_regfile,
  input  logic                 mem_destmux_sel,
  input  logic [2:0]           mem_dest,
  input  logic [1:0]           mem_regfilemux_sel,
  input  logic                 mem_load_cc,
  input  logic                 mem_br,
  input  logic [2:0]           mem_nzp,
  input  logic [15:0]          mem_alu,
  input  logic [15:0]          mem_mdr,
  input  logic [15:0]          mem_pc,
  input  logic                 mem_addr0,
  output logic [15:0]          regfilemux_out,
  output logic                 load_regfile,
  output logic [2:0]           destb,
  output logic                 destmux_sel,
  output logic [2:0]           cc,
  output logic                 br_taken,
  output logic                 wb_valid,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [1:0] {
    SEL_ALU  = 2'b00,
    SEL_MDR  = 2'b01,
    SEL_PC   = 2'b10,
    SEL_BYTE = 2'b11
  } rf_sel_e;

  typedef struct packed {
    logic        valid;
    logic        load_regfile;
    logic        destmux_sel;
    logic [2:0]  dest;
    rf_sel_e     regfilemux_sel;
    logic        load_cc;
    logic        br;
    logic [2:0]  nzp;
    logic [15:0] alu;
    logic [15:0] mdr;
    logic [15:0] pc;
    logic        addr0;
  } wb_reg_t;

  wb_reg_t              wb_q;
  logic [2:0]           cc_q;
  logic [CNT_WIDTH-1:0] retired_q;
  logic [15:0]          wb_data;
  logic [2:0]           nzp_gen;
  logic                 commit;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_q <= '0;
    end else if (stall_in) begin
      wb_q <= wb_q;
    end else if (flush_in) begin
      wb_q <= '0;
    end else begin
      wb_q <= '{valid:          mem_valid,
                load_regfile:   mem_load_regfile,
                destmux_sel:    mem_destmux_sel,
                dest:           mem_dest,
                regfilemux_sel: rf_sel_e'(mem_regfilemux_sel),
                load_cc:        mem_load_cc,
                br:             mem_br,
                nzp:            mem_nzp,
                alu:            mem_alu,
                mdr:            mem_mdr,
                pc:             mem_pc,
                addr0:          mem_addr0};
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wb_data = wb_q.alu;
    unique case (wb_q.regfilemux_sel)
      SEL_ALU:  wb_data = wb_q.alu;
      SEL_MDR:  wb_data = wb_q.mdr;
      SEL_PC:   wb_data = wb_q.pc;
      SEL_BYTE: wb_data = {8'h00, wb_q.addr0 ? wb_q.mdr[15:8] : wb_q.mdr[7:0]};
      default:  wb_data = wb_q.alu;
    endcase
  end

  always_comb begin
    nzp_gen = 3'b001;
    if (wb_data[15])
      nzp_gen = 3'b100;
    else if (wb_data == 16'h0000)
      nzp_gen = 3'b010;
  end

  // The WB instruction commits on the first edge it sees with stall low.
  assign commit = wb_q.valid & ~stall_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cc_q      <= 3'b010;
      retired_q <= '0;
    end else begin
      if (commit && wb_q.load_cc)
        cc_q <= nzp_gen;
      if (commit)
        retired_q <= retired_q + CNT_WIDTH'(1);
    end
  end

  assign regfilemux_out = wb_data;
  assign load_regfile   = commit & wb_q.load_regfile;
  assign destb          = wb_q.dest;
  assign destmux_sel    = wb_q.destmux_sel;
  assign cc             = cc_q;
  // Branch reads the committed CC; any earlier CC writer has already retired.
  assign br_taken       = wb_q.valid & wb_q.br & (|(wb_q.nzp & cc_q));
  assign wb_valid       = wb_q.valid;
  assign retired        = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: table-driven pipeline stream with a
// scoreboard queue, followed by stall, flush and mid-write reset sequences.
module tb_writeback_stage;

  localparam int CNT_WIDTH = 16;

  logic                 clk;
  logic                 reset_n;
  logic                 stall_in;
  logic                 flush_in;
  logic                 mem_valid;
  logic                 mem_load_regfile;
  logic                 mem_destmux_sel;
  logic [2:0]           mem_dest;
  logic [1:0]           mem_regfilemux_sel;
  logic                 mem_load_cc;
  logic                 mem_br;
  logic [2:0]           mem_nzp;
  logic [15:0]          mem_alu;
  logic [15:0]          mem_mdr;
  logic [15:0]          mem_pc;
  logic                 mem_addr0;
  logic [15:0]          regfilemux_out;
  logic                 load_regfile;
  logic [2:0]           destb;
  logic                 destmux_sel;
  logic [2:0]           cc;
  logic                 br_taken;
  logic                 wb_valid;
  logic [CNT_WIDTH-1:0] retired;

  writeback_stage #(.CNT_WIDTH(CNT_WIDTH)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .stall_in           (stall_in),
    .flush_in           (flush_in),
    .mem_valid          (mem_valid),
    .mem_load_regfile   (mem_load_regfile),
    .mem_destmux_sel    (mem_destmux_sel),
    .mem_dest           (mem_dest),
    .mem_regfilemux_sel (mem_regfilemux_sel),
    .mem_load_cc        (mem_load_cc),
    .mem_br             (mem_br),
    .mem_nzp            (mem_nzp),
    .mem_alu            (mem_alu),
    .mem_mdr            (mem_mdr),
    .mem_pc             (mem_pc),
    .mem_addr0          (mem_addr0),
    .regfilemux_out     (regfilemux_out),
    .load_regfile       (load_regfile),
    .destb              (destb),
    .destmux_sel        (destmux_sel),
    .cc                 (cc),
    .br_taken           (br_taken),
    .wb_valid           (wb_valid),
    .retired            (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One instruction plus what WB must show for it; exp_cc is the CC left by
  // its predecessors, visible while it sits in WB.
  typedef struct {
    logic        ld;
    logic        dsel;
    logic [2:0]  dest;
    logic [1:0]  sel;
    logic        lcc;
    logic        br;
    logic [2:0]  nzp;
    logic [15:0] alu;
    logic [15:0] mdr;
    logic [15:0] pc;
    logic        a0;
    logic [15:0] exp_data;
    logic        exp_br;
    logic [2:0]  exp_cc;
  } vec_t;

  localparam int N_VEC = 12;
  vec_t tbl [N_VEC];
  vec_t sb_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v, input logic valid);
    mem_valid          = valid;
    mem_load_regfile   = v.ld;
    mem_destmux_sel    = v.dsel;
    mem_dest           = v.dest;
    mem_regfilemux_sel = v.sel;
    mem_load_cc        = v.lcc;
    mem_br             = v.br;
    mem_nzp            = v.nzp;
    mem_alu            = v.alu;
    mem_mdr            = v.mdr;
    mem_pc             = v.pc;
    mem_addr0          = v.a0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t bub;
    vec_t jsr;
    vec_t ccw;
    vec_t v;
    int   exp_ret;
    int   writes;

    bub = '{ld:0, dsel:0, dest:0, sel:0, lcc:0, br:0, nzp:0, alu:0, mdr:0, pc:0, a0:0,
            exp_data:0, exp_br:0, exp_cc:0};
    jsr = '{ld:1, dsel:1, dest:3'd2, sel:2'b10, lcc:0, br:0, nzp:0, alu:16'h1111,
            mdr:16'h2222, pc:16'h3002, a0:0, exp_data:16'h3002, exp_br:0, exp_cc:0};
    ccw = '{ld:1, dsel:0, dest:3'd4, sel:2'b00, lcc:1, br:0, nzp:0, alu:16'h8000,
            mdr:0, pc:0, a0:0, exp_data:16'h8000, exp_br:0, exp_cc:0};

    //          ld dsel dest  sel    lcc br nzp     alu       mdr       pc        a0 data     br cc
    tbl[0]  = '{1, 0, 3'd3, 2'b00, 1, 0, 3'b000, 16'h8000, 16'h0000, 16'h0000, 0, 16'h8000, 0, 3'b010};
    tbl[1]  = '{1, 0, 3'd1, 2'b00, 1, 0, 3'b000, 16'h0000, 16'hFFFF, 16'h1234, 0, 16'h0000, 0, 3'b100};
    tbl[2]  = '{0, 0, 3'd0, 2'b00, 0, 1, 3'b010, 16'h1234, 16'h0000, 16'h0000, 0, 16'h1234, 1, 3'b010};
    tbl[3]  = '{0, 0, 3'd0, 2'b00, 0, 1, 3'b101, 16'h4321, 16'h0000, 16'h0000, 0, 16'h4321, 0, 3'b010};
    tbl[4]  = '{1, 0, 3'd5, 2'b11, 1, 0, 3'b000, 16'h0000, 16'hA55A, 16'h0000, 1, 16'h00A5, 0, 3'b010};
    tbl[5]  = '{1, 0, 3'd6, 2'b11, 1, 0, 3'b000, 16'h0000, 16'hA55A, 16'h0000, 0, 16'h005A, 0, 3'b001};
    tbl[6]  = '{1, 0, 3'd7, 2'b01, 1, 0, 3'b000, 16'h0F0F, 16'hF00F, 16'h0000, 1, 16'hF00F, 0, 3'b001};
    tbl[7]  = '{1, 1, 3'd2, 2'b10, 0, 0, 3'b000, 16'h0000, 16'h0000, 16'h3002, 0, 16'h3002, 0, 3'b100};
    tbl[8]  = '{0, 0, 3'd0, 2'b00, 0, 1, 3'b100, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 1, 3'b100};
    tbl[9]  = '{0, 0, 3'd0, 2'b00, 0, 1, 3'b011, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 3'b100};
    tbl[10] = '{1, 0, 3'd0, 2'b00, 1, 0, 3'b000, 16'h0001, 16'h0000, 16'h0000, 0, 16'h0001, 0, 3'b100};
    tbl[11] = '{0, 0, 3'd0, 2'b00, 0, 1, 3'b001, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 1, 3'b001};

    stall_in = 1'b0;
    flush_in = 1'b0;
    drive(bub, 1'b0);
    reset_n = 1'b1;
    #1 reset_n = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_wb_valid",     32'(wb_valid),       32'h0);
    check("rst_cc",           32'(cc),             32'h2);
    check("rst_retired",      32'(retired),        32'h0);
    check("rst_load_regfile", 32'(load_regfile),   32'h0);
    check("rst_br_taken",     32'(br_taken),       32'h0);
    check("rst_data",         32'(regfilemux_out), 32'h0);
    check("rst_destb",        32'(destb),          32'h0);
    check("rst_destmux_sel",  32'(destmux_sel),    32'h0);
    reset_n = 1'b1;

    // Back-to-back stream through the scoreboard
    exp_ret = 0;
    for (int i = 0; i <= N_VEC; i++) begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        v = sb_q.pop_front();
        check($sformatf("v%0d_wb_valid", exp_ret),     32'(wb_valid),       32'h1);
        check($sformatf("v%0d_data", exp_ret),         32'(regfilemux_out), 32'(v.exp_data));
        check($sformatf("v%0d_load_regfile", exp_ret), 32'(load_regfile),   32'(v.ld));
        check($sformatf("v%0d_destb", exp_ret),        32'(destb),          32'(v.dest));
        check($sformatf("v%0d_destmux_sel", exp_ret),  32'(destmux_sel),    32'(v.dsel));
        check($sformatf("v%0d_br_taken", exp_ret),     32'(br_taken),       32'(v.exp_br));
        check($sformatf("v%0d_cc", exp_ret),           32'(cc),             32'(v.exp_cc));
        check($sformatf("v%0d_retired", exp_ret),      32'(retired),        32'(exp_ret));
        exp_ret++;
      end
      if (i < N_VEC) begin
        drive(tbl[i], 1'b1);
        sb_q.push_back(tbl[i]);
      end else begin
        drive(bub, 1'b0);
      end
    end
    @(negedge clk);
    check("stream_final_cc",      32'(cc),       32'h1);
    check("stream_final_retired", 32'(retired),  32'(exp_ret));
    check("stream_final_valid",   32'(wb_valid), 32'h0);

    // JSR held by a 3-cycle stall, with a flush request that must be ignored
    drive(jsr, 1'b1);
    @(negedge clk);
    stall_in = 1'b1;
    flush_in = 1'b1;
    drive(ccw, 1'b1);
    writes = 0;
    #1;
    writes += int'(load_regfile);
    check("stall0_load_regfile", 32'(load_regfile),   32'h0);
    check("stall0_data",         32'(regfilemux_out), 32'h3002);
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      writes += int'(load_regfile);
      check($sformatf("stall%0d_load_regfile", k), 32'(load_regfile), 32'h0);
      check($sformatf("stall%0d_wb_valid", k),     32'(wb_valid),     32'h1);
      check($sformatf("stall%0d_retired", k),      32'(retired),      32'(exp_ret));
      check($sformatf("stall%0d_data", k),         32'(regfilemux_out), 32'h3002);
    end
    @(negedge clk);
    stall_in = 1'b0;
    flush_in = 1'b0;
    drive(bub, 1'b0);
    #1;
    writes += int'(load_regfile);
    check("release_load_regfile", 32'(load_regfile),   32'h1);
    check("release_data",         32'(regfilemux_out), 32'h3002);
    check("release_destmux_sel",  32'(destmux_sel),    32'h1);
    check("release_destb",        32'(destb),          32'h2);
    check("release_retired",      32'(retired),        32'(exp_ret));
    @(negedge clk);
    writes += int'(load_regfile);
    exp_ret++;
    check("jsr_retired",     32'(retired),  32'(exp_ret));
    check("jsr_write_count", 32'(writes),   32'h1);
    check("jsr_cc",          32'(cc),       32'h1);
    check("jsr_after_valid", 32'(wb_valid), 32'h0);

    // Flush of a valid CC-setting instruction
    drive(ccw, 1'b1);
    flush_in = 1'b1;
    @(negedge clk);
    flush_in = 1'b0;
    drive(bub, 1'b0);
    check("flush_wb_valid",     32'(wb_valid),     32'h0);
    check("flush_load_regfile", 32'(load_regfile), 32'h0);
    check("flush_br_taken",     32'(br_taken),     32'h0);
    @(negedge clk);
    check("flush_cc",      32'(cc),      32'h1);
    check("flush_retired", 32'(retired), 32'(exp_ret));

    // Asynchronous reset in the middle of a write
    drive(ccw, 1'b1);
    @(negedge clk);
    drive(bub, 1'b0);
    check("prerst_load_regfile", 32'(load_regfile),   32'h1);
    check("prerst_data",         32'(regfilemux_out), 32'h8000);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_load_regfile", 32'(load_regfile), 32'h0);
    check("midrst_wb_valid",     32'(wb_valid),     32'h0);
    check("midrst_cc",           32'(cc),           32'h2);
    check("midrst_retired",      32'(retired),      32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("postrst_cc",      32'(cc),      32'h2);
    check("postrst_retired", 32'(retired), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
